// File: rtl/hazard3_reset_seq.sv
// Reset sequencer: one ASSERT/RELEASE/IDLE channel per hart plus one system channel.
// All outputs are registered from next state, so they change on the same edge as the state; the sequencer has no backpressure, requests are levels.
module hazard3_reset_seq #(
   parameter int N_HARTS        = 1,
   parameter int ASSERT_CYCLES  = 4,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sys_reset_req,
   input  logic [N_HARTS-1:0] hart_reset_req,
   output logic               rst_n_sys,
   output logic [N_HARTS-1:0] rst_n_hart,
   output logic               sys_reset_done,
   output logic [N_HARTS-1:0] hart_reset_done,
   output logic               reset_busy
);

   localparam int NCH  = N_HARTS + 1;
   localparam int MAXC = (ASSERT_CYCLES > RELEASE_CYCLES) ? ASSERT_CYCLES : RELEASE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] ASSERT_LOAD  = CW'(ASSERT_CYCLES - 1);
   localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      CH_ASSERT  = 2'd0,
      CH_RELEASE = 2'd1,
      CH_IDLE    = 2'd2
   } ch_state_t;

   ch_state_t       state_q [NCH];
   ch_state_t       state_d [NCH];
   logic [CW-1:0]   cnt_q   [NCH];
   logic [CW-1:0]   cnt_d   [NCH];
   logic [NCH-1:0]  req;
   logic [NCH-1:0]  assert_d;
   logic [NCH-1:0]  idle_d;

   // A system request also resets every hart; the top channel is the system itself.
   always_comb begin
      req = {sys_reset_req, hart_reset_req | {N_HARTS{sys_reset_req}}};
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            CH_IDLE: begin
               if (req[i]) begin
                  state_d[i] = CH_ASSERT;
                  cnt_d[i]   = ASSERT_LOAD;
               end
            end
            CH_ASSERT: begin
               // Counter saturates at zero so a held request never wraps it.
               if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end else if (!req[i]) begin
                  state_d[i] = CH_RELEASE;
                  cnt_d[i]   = RELEASE_LOAD;
               end
            end
            CH_RELEASE: begin
               if (req[i]) begin
                  state_d[i] = CH_ASSERT;
                  cnt_d[i]   = ASSERT_LOAD;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = CH_IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end
            end
            default: begin
               state_d[i] = CH_ASSERT;
               cnt_d[i]   = ASSERT_LOAD;
            end
         endcase
         assert_d[i] = (state_d[i] == CH_ASSERT);
         idle_d[i]   = (state_d[i] == CH_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= CH_ASSERT;
            cnt_q[i]   <= ASSERT_LOAD;
         end
         rst_n_sys       <= 1'b0;
         rst_n_hart      <= '0;
         sys_reset_done  <= 1'b0;
         hart_reset_done <= '0;
         reset_busy      <= 1'b1;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         rst_n_sys       <= ~assert_d[N_HARTS];
         rst_n_hart      <= ~assert_d[N_HARTS-1:0];
         sys_reset_done  <= &idle_d;
         hart_reset_done <= idle_d[N_HARTS-1:0];
         reset_busy      <= ~(&idle_d);
      end
   end

endmodule

// File: tb/tb_hazard3_reset_seq.sv
// Bench for hazard3_reset_seq with two harts: directed edge-timed scenarios plus random requests.
module tb_hazard3_reset_seq;

   localparam int NH = 2;
   localparam int AC = 4;
   localparam int RC = 2;

   logic          clk;
   logic          rst_n;
   logic          sys_reset_req;
   logic [NH-1:0] hart_reset_req;
   logic          rst_n_sys;
   logic [NH-1:0] rst_n_hart;
   logic          sys_reset_done;
   logic [NH-1:0] hart_reset_done;
   logic          reset_busy;
   logic [6:0]    dut_o;

   int vectors;
   int miscompares;
   int edge_no;

   // Model per channel: phase 0 = holding reset, 1 = released, 2 = done; age = edges spent in phase.
   int phase [3];
   int age   [3];

   hazard3_reset_seq #(
      .N_HARTS(NH), .ASSERT_CYCLES(AC), .RELEASE_CYCLES(RC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .sys_reset_req(sys_reset_req), .hart_reset_req(hart_reset_req),
      .rst_n_sys(rst_n_sys), .rst_n_hart(rst_n_hart),
      .sys_reset_done(sys_reset_done), .hart_reset_done(hart_reset_done),
      .reset_busy(reset_busy)
   );

   assign dut_o = {rst_n_sys, rst_n_hart, sys_reset_done, hart_reset_done, reset_busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void model_reset();
      for (int c = 0; c < 3; c++) begin
         phase[c] = 0;
         age[c]   = 1;
      end
   endfunction

   function automatic void model_step(input logic s, input logic [NH-1:0] h);
      logic [2:0] r;
      r = {s, h | {NH{s}}};
      for (int c = 0; c < 3; c++) begin
         if (phase[c] == 2) begin
            if (r[c]) begin phase[c] = 0; age[c] = 1; end
         end else if (phase[c] == 0) begin
            if (age[c] >= AC && !r[c]) begin phase[c] = 1; age[c] = 1; end
            else age[c]++;
         end else begin
            if (r[c]) begin phase[c] = 0; age[c] = 1; end
            else if (age[c] >= RC) phase[c] = 2;
            else age[c]++;
         end
      end
   endfunction

   function automatic logic [6:0] model_o();
      logic [2:0] low;
      logic [2:0] done;
      for (int c = 0; c < 3; c++) begin
         low[c]  = (phase[c] == 0);
         done[c] = (phase[c] == 2);
      end
      return {~low[2], ~low[1:0], &done, done[1:0], ~(&done)};
   endfunction

   task automatic tick(input logic s, input logic [NH-1:0] h);
      sys_reset_req  = s;
      hart_reset_req = h;
      @(posedge clk);
      model_step(s, h);
      edge_no++;
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] exp_o;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      exp_o = 7'b0000001;
      vectors++;
      if (dut_o !== exp_o) begin
         $display("FAIL reset_values: got %b want %b", dut_o, exp_o);
         miscompares++;
      end
      vectors++;
      if (dut_o !== model_o()) begin
         $display("FAIL reset_model: got %b want %b", dut_o, model_o());
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      edge_no = -1;
   endtask

   task automatic test_power_on(input int n_edges);
      logic [6:0] exp_o;
      logic up, dn;
      for (int k = 0; k < n_edges; k++) begin
         tick(1'b0, 2'b00);
         up = (edge_no >= 3);
         dn = (edge_no >= 5);
         exp_o = {up, up, up, dn, dn, dn, ~dn};
         vectors++;
         if (dut_o !== exp_o) begin
            $display("FAIL power_on edge %0d: got %b want %b", edge_no, dut_o, exp_o);
            miscompares++;
         end
         vectors++;
         if (dut_o !== model_o()) begin
            $display("FAIL power_on_model edge %0d: got %b want %b", edge_no, dut_o, model_o());
            miscompares++;
         end
      end
   endtask

   task automatic test_hart_pulse();
      logic [6:0] exp_o;
      logic r0, d0;
      while (edge_no < 39) begin
         tick(1'b0, (edge_no + 1 == 20) ? 2'b01 : 2'b00);
         r0 = !(edge_no >= 20 && edge_no <= 23);
         d0 = !(edge_no >= 20 && edge_no <= 25);
         exp_o = {1'b1, 1'b1, r0, d0, 1'b1, d0, ~d0};
         vectors++;
         if (dut_o !== exp_o) begin
            $display("FAIL hart_pulse edge %0d: got %b want %b", edge_no, dut_o, exp_o);
            miscompares++;
         end
      end
   endtask

   task automatic test_sys_hold();
      logic [6:0] exp_o;
      logic lo, dn;
      while (edge_no < 59) begin
         tick((edge_no + 1 >= 40 && edge_no + 1 <= 49), 2'b00);
         lo = (edge_no >= 40 && edge_no <= 49);
         dn = !(edge_no >= 40 && edge_no <= 51);
         exp_o = {~lo, ~lo, ~lo, dn, dn, dn, ~dn};
         vectors++;
         if (dut_o !== exp_o) begin
            $display("FAIL sys_hold edge %0d: got %b want %b", edge_no, dut_o, exp_o);
            miscompares++;
         end
      end
   endtask

   task automatic test_rerequest();
      logic [6:0] exp_o;
      logic lo, d1;
      while (edge_no < 79) begin
         tick(1'b0, (edge_no + 1 == 60 || edge_no + 1 == 65) ? 2'b10 : 2'b00);
         lo = (edge_no >= 60 && edge_no <= 63) || (edge_no >= 65 && edge_no <= 68);
         d1 = !(edge_no >= 60 && edge_no <= 70);
         exp_o = {1'b1, ~lo, 1'b1, d1, d1, 1'b1, ~d1};
         vectors++;
         if (dut_o !== exp_o) begin
            $display("FAIL rerequest edge %0d: got %b want %b", edge_no, dut_o, exp_o);
            miscompares++;
         end
      end
   endtask

   task automatic test_random(input int n_cycles);
      logic s;
      logic [NH-1:0] h;
      for (int k = 0; k < n_cycles; k++) begin
         s = ($urandom_range(0, 24) == 0);
         h[0] = ($urandom_range(0, 9) == 0);
         h[1] = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) begin
            // Occasional long hold to exercise counter saturation.
            for (int j = 0; j < 12; j++) begin
               tick(s, h);
               vectors++;
               if (dut_o !== model_o()) begin
                  $display("FAIL random_hold cycle %0d: got %b want %b", k, dut_o, model_o());
                  miscompares++;
               end
            end
         end
         tick(s, h);
         vectors++;
         if (dut_o !== model_o()) begin
            $display("FAIL random cycle %0d in %b/%b: got %b want %b", k, s, h, dut_o, model_o());
            miscompares++;
         end
      end
   endtask

   task automatic test_async_reset();
      tick(1'b0, 2'b00);
      tick(1'b0, 2'b01);
      tick(1'b0, 2'b00);
      vectors++;
      if (rst_n_hart[0] !== 1'b0) begin
         $display("FAIL async_setup: rst_n_hart0 got %b want 0", rst_n_hart[0]);
         miscompares++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (dut_o !== 7'b0000001) begin
         $display("FAIL async_reset_immediate: got %b want %b", dut_o, 7'b0000001);
         miscompares++;
      end
      sys_reset_req  = 1'b0;
      hart_reset_req = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (dut_o !== 7'b0000001) begin
         $display("FAIL async_reset_held: got %b want %b", dut_o, 7'b0000001);
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      edge_no = -1;
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      edge_no        = -1;
      rst_n          = 1'b0;
      sys_reset_req  = 1'b0;
      hart_reset_req = '0;
      test_reset();
      test_power_on(20);
      test_hart_pulse();
      test_sys_hold();
      test_rerequest();
      test_random(400);
      test_async_reset();
      test_power_on(10);
      test_random(200);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
